// File: rtl/fp_mul_pkg.sv
// Shared types and format helpers for the parameterized floating-point multiplier.
package fp_mul_pkg;

  typedef enum logic [1:0] {
    RNE = 2'b00,
    RTZ = 2'b01,
    RDN = 2'b10,
    RUP = 2'b11
  } rnd_mode_e;

  localparam int DEF_EXPO_W = 8;
  localparam int DEF_MANT_W = 23;
  localparam int DEF_BIAS   = (1 << (DEF_EXPO_W - 1)) - 1;
  localparam int MAX_FMT_W  = 64;

  function automatic int expo_bias(input int expo_w);
    return (1 << (expo_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: positive, all-ones exponent, only the fraction MSB set.
  function automatic logic [MAX_FMT_W-1:0] qnan_bits(input int expo_w, input int mant_w);
    logic [MAX_FMT_W-1:0] ones;
    ones = {MAX_FMT_W{1'b1}} >> (MAX_FMT_W - expo_w);
    return (ones << mant_w) | (MAX_FMT_W'(1) << (mant_w - 1));
  endfunction

endpackage

// File: rtl/fp_mul_round.sv
// Rounds a normalized wide significand into a packed result, handling gradual
// underflow into subnormals and mode-dependent overflow saturation.
module fp_mul_round
  import fp_mul_pkg::*;
#(
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23
) (
  input  logic                       sign,
  input  logic signed [EXPO_W+1:0]   exp_in,
  input  logic [2*MANT_W+1:0]        sig_in,
  input  logic [1:0]                 rnd,
  output logic [EXPO_W+MANT_W:0]     res
);

  localparam int PROD_W   = 2*MANT_W + 2;
  localparam int EXP_SW   = EXPO_W + 2;
  localparam int SH_MAX   = MANT_W + 3;
  localparam int SH_W     = $clog2(SH_MAX + 1);
  localparam int PK_W     = EXP_SW + MANT_W;
  localparam int EXP_ONES = (1 << EXPO_W) - 1;

  logic              underflow;
  logic [EXP_SW-1:0] diff;
  logic [SH_W-1:0]   sh;
  logic [PROD_W-1:0] shifted;
  logic              lost;
  logic [EXP_SW-1:0] e_field;
  logic [MANT_W-1:0] frac;
  logic              g, r, st, inc;
  logic [PK_W-1:0]   packed_sum;
  logic [EXP_SW-1:0] rexp;
  logic              ovf;

  // Denormalize when the exponent falls below 1; beyond MANT_W+3 everything is sticky.
  always_comb begin
    underflow = exp_in < $signed(EXP_SW'(1));
    diff      = EXP_SW'(1) - exp_in;
    sh        = '0;
    if (underflow)
      sh = (diff > EXP_SW'(SH_MAX)) ? SH_W'(SH_MAX) : diff[SH_W-1:0];
  end

  assign shifted = sig_in >> sh;
  assign lost    = |(sig_in & ~({PROD_W{1'b1}} << sh));

  // A denormalized significand has a zero hidden bit, which leaves the exponent field at 0.
  assign e_field = underflow ? {{(EXP_SW-1){1'b0}}, shifted[PROD_W-1]} : $unsigned(exp_in);
  assign frac    = shifted[PROD_W-2 -: MANT_W];
  assign g       = shifted[MANT_W];
  assign r       = shifted[MANT_W-1];
  assign st      = (|shifted[MANT_W-2:0]) | lost;

  always_comb begin
    inc = 1'b0;
    case (rnd_mode_e'(rnd))
      RNE: inc = g & (r | st | frac[0]);
      RTZ: inc = 1'b0;
      RDN: inc = sign & (g | r | st);
      RUP: inc = ~sign & (g | r | st);
      default: inc = 1'b0;
    endcase
  end

  // Adding into {exponent, fraction} lets a fraction carry bump the exponent directly.
  assign packed_sum = {e_field, frac} + PK_W'(inc);
  assign rexp       = packed_sum[PK_W-1 -: EXP_SW];
  assign ovf        = rexp >= EXP_SW'(EXP_ONES);

  always_comb begin
    res = {sign, rexp[EXPO_W-1:0], packed_sum[MANT_W-1:0]};
    if (ovf) begin
      case (rnd_mode_e'(rnd))
        RTZ:     res = {sign, EXPO_W'(EXP_ONES - 1), {MANT_W{1'b1}}};
        RDN:     res = sign ? {1'b1, {EXPO_W{1'b1}}, {MANT_W{1'b0}}}
                            : {1'b0, EXPO_W'(EXP_ONES - 1), {MANT_W{1'b1}}};
        RUP:     res = sign ? {1'b1, EXPO_W'(EXP_ONES - 1), {MANT_W{1'b1}}}
                            : {1'b0, {EXPO_W{1'b1}}, {MANT_W{1'b0}}};
        default: res = {sign, {EXPO_W{1'b1}}, {MANT_W{1'b0}}};
      endcase
    end
  end

endmodule

// File: rtl/fp_mul_para.sv
// Parameterized IEEE-754-style multiplier: combinational unpack/multiply/normalize,
// rounding in fp_mul_round, one registered output stage.
module fp_mul_para
  import fp_mul_pkg::*;
#(
  parameter int SIGN_W = 1,
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [SIGN_W+EXPO_W+MANT_W-1:0]  a,
  input  logic [SIGN_W+EXPO_W+MANT_W-1:0]  b,
  input  logic [1:0]                       rnd,
  output logic [SIGN_W+EXPO_W+MANT_W-1:0]  res
);

  localparam int W      = SIGN_W + EXPO_W + MANT_W;
  localparam int PROD_W = 2*MANT_W + 2;
  localparam int EXP_SW = EXPO_W + 2;
  localparam int LZ_W   = $clog2(PROD_W + 1);
  localparam int BIAS   = expo_bias(EXPO_W);
  localparam logic [W-1:0] QNAN = W'(qnan_bits(EXPO_W, MANT_W));

  logic                     sign_a, sign_b, sign_r;
  logic [EXPO_W-1:0]        exp_a, exp_b, eff_a, eff_b;
  logic [MANT_W-1:0]        frac_a, frac_b;
  logic                     a_max, a_min, a_fz, b_max, b_min, b_fz;
  logic                     a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
  logic                     is_nan, is_inf, is_zero;
  logic [PROD_W-1:0]        prod, norm_sig;
  logic signed [EXP_SW-1:0] exp_raw, norm_exp;
  logic [LZ_W-1:0]          lz;
  logic                     found;
  logic [W-1:0]             rounded, res_next;

  assign {sign_a, exp_a, frac_a} = a;
  assign {sign_b, exp_b, frac_b} = b;
  assign sign_r = sign_a ^ sign_b;

  assign a_max = &exp_a;
  assign a_min = ~|exp_a;
  assign a_fz  = ~|frac_a;
  assign b_max = &exp_b;
  assign b_min = ~|exp_b;
  assign b_fz  = ~|frac_b;

  assign a_nan  = a_max & ~a_fz;
  assign a_inf  = a_max & a_fz;
  assign a_zero = a_min & a_fz;
  assign b_nan  = b_max & ~b_fz;
  assign b_inf  = b_max & b_fz;
  assign b_zero = b_min & b_fz;

  assign is_nan  = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
  assign is_inf  = a_inf | b_inf;
  assign is_zero = a_zero | b_zero;

  // Subnormal operands use exponent 1 with a clear hidden bit.
  assign eff_a = a_min ? EXPO_W'(1) : exp_a;
  assign eff_b = b_min ? EXPO_W'(1) : exp_b;
  assign prod  = PROD_W'({~a_min, frac_a}) * PROD_W'({~b_min, frac_b});
  assign exp_raw = $signed(EXP_SW'(eff_a)) + $signed(EXP_SW'(eff_b)) - $signed(EXP_SW'(BIAS));

  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = PROD_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (prod[i]) found = 1'b1;
        else         lz    = lz + LZ_W'(1);
      end
    end
  end

  // Hidden bit lands at the product MSB; binary point sits one below it.
  assign norm_sig = prod << lz;
  assign norm_exp = exp_raw + $signed(EXP_SW'(1)) - $signed(EXP_SW'(lz));

  fp_mul_round #(
    .EXPO_W (EXPO_W),
    .MANT_W (MANT_W)
  ) u_round (
    .sign   (sign_r),
    .exp_in (norm_exp),
    .sig_in (norm_sig),
    .rnd    (rnd),
    .res    (rounded)
  );

  always_comb begin
    res_next = rounded;
    if (is_nan)       res_next = QNAN;
    else if (is_inf)  res_next = {sign_r, {EXPO_W{1'b1}}, {MANT_W{1'b0}}};
    else if (is_zero) res_next = {sign_r, {(EXPO_W+MANT_W){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) res <= '0;
    else        res <= res_next;
  end

endmodule

// File: tb/tb_fp_mul_para.sv
// Scoreboard bench for fp_mul_para (binary32): directed vector table, reset sequences
// and back-to-back random operands against an integer-arithmetic reference model.
module tb_fp_mul_para;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  rnd;
    logic [31:0] expv;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b, res;
  logic [1:0]  rnd;

  int   errors = 0;
  int   checks = 0;
  vec_t sb[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  fp_mul_para #(
    .SIGN_W (1),
    .EXPO_W (8),
    .MANT_W (23)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .rnd   (rnd),
    .res   (res)
  );

  // Reference: exact product p*2^e rounded to the binary32 grid by remainder comparison.
  function automatic logic [31:0] fpModel(input logic [31:0] x, input logic [31:0] y,
                                          input logic [1:0] md);
    logic        s, nanx, nany, infx, infy, zx, zy, gt, tie, nz, inc;
    logic [7:0]  ex, ey;
    logic [22:0] fx, fy;
    logic [63:0] p, m, rem, half;
    int          e, k, eu, sh, bexp;
    s  = x[31] ^ y[31];
    ex = x[30:23]; fx = x[22:0];
    ey = y[30:23]; fy = y[22:0];
    nanx = (ex == 8'hFF) && (fx != 23'd0);
    nany = (ey == 8'hFF) && (fy != 23'd0);
    infx = (ex == 8'hFF) && (fx == 23'd0);
    infy = (ey == 8'hFF) && (fy == 23'd0);
    zx   = (ex == 8'h00) && (fx == 23'd0);
    zy   = (ey == 8'h00) && (fy == 23'd0);
    if (nanx || nany || (infx && zy) || (zx && infy)) return 32'h7FC00000;
    if (infx || infy) return {s, 8'hFF, 23'd0};
    if (zx || zy) return {s, 31'd0};
    p = {40'd0, (ex != 8'h00), fx} * {40'd0, (ey != 8'h00), fy};
    e = ((ex == 8'h00) ? 1 : int'(ex)) - 150 + ((ey == 8'h00) ? 1 : int'(ey)) - 150;
    k = 0;
    for (int i = 0; i < 64; i++) if (p[i]) k = i;
    eu = k + e;
    if (eu < -126) eu = -126;
    sh   = (eu - 23) - e;
    gt   = 1'b0; tie = 1'b0; nz = 1'b0;
    rem  = '0;   half = '0;
    if (sh <= 0) begin
      m = p << (-sh);
    end else if (sh >= 60) begin
      m  = '0;
      nz = 1'b1;
    end else begin
      m    = p >> sh;
      rem  = p & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      gt   = rem > half;
      tie  = rem == half;
      nz   = rem != 64'd0;
    end
    case (md)
      2'd0:    inc = gt | (tie & m[0]);
      2'd1:    inc = 1'b0;
      2'd2:    inc = s & nz;
      default: inc = ~s & nz;
    endcase
    m = m + {63'd0, inc};
    if (m[24]) begin
      m  = m >> 1;
      eu = eu + 1;
    end
    if (!m[23]) return {s, 8'd0, m[22:0]};
    bexp = eu + 127;
    if (bexp >= 255) begin
      case (md)
        2'd0:    return {s, 8'hFF, 23'd0};
        2'd1:    return {s, 8'hFE, 23'h7FFFFF};
        2'd2:    return s ? 32'hFF800000 : 32'h7F7FFFFF;
        default: return s ? 32'hFF7FFFFF : 32'h7F800000;
      endcase
    end
    return {s, bexp[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] randOp();
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom);
    e = 8'($urandom_range(0, 255));
    case ($urandom_range(0, 9))
      0: begin e = 8'h00; f = 23'd0; end
      1: begin e = 8'hFF; f = 23'd0; end
      2: begin e = 8'hFF; if (f == 23'd0) f = 23'd1; end
      3: e = 8'h00;
      4: e = 8'($urandom_range(200, 254));
      5: e = 8'($urandom_range(1, 40));
      6: e = 8'($urandom_range(120, 134));
      default: ;
    endcase
    return {s, e, f};
  endfunction

  task automatic applyStimulus(input string name, input logic rst_val, input logic [31:0] va,
                               input logic [31:0] vb, input logic [1:0] vr,
                               input logic [31:0] expv);
    vec_t item;
    @(negedge clk);
    rst_n = rst_val;
    a     = va;
    b     = vb;
    rnd   = vr;
    item.name = name;
    item.a    = va;
    item.b    = vb;
    item.rnd  = vr;
    item.expv = expv;
    sb.push_back(item);
  endtask

  task automatic checkOutput(input vec_t item);
    checks++;
    if (res !== item.expv) begin
      errors++;
      $display("[TB] FAIL %s: a=%08h b=%08h rnd=%0d res=%08h expected=%08h",
               item.name, item.a, item.b, item.rnd, res, item.expv);
    end
  endtask

  // Each vector driven before a rising edge is compared just after that edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) checkOutput(sb.pop_front());
  end

  initial begin
    logic [31:0] ra, rb;
    rst_n = 1'b0;
    a     = '0;
    b     = '0;
    rnd   = 2'b00;

    vecs.push_back('{"one_sq",     32'h3F800000, 32'h3F800000, 2'b00, 32'h3F800000});
    vecs.push_back('{"two_x3",     32'h40000000, 32'h40400000, 2'b00, 32'h40C00000});
    vecs.push_back('{"negzero",    32'h80000000, 32'h3F800000, 2'b00, 32'h80000000});
    vecs.push_back('{"rnd_rne",    32'h3F800001, 32'h3F800001, 2'b00, 32'h3F800002});
    vecs.push_back('{"rnd_rtz",    32'h3F800001, 32'h3F800001, 2'b01, 32'h3F800002});
    vecs.push_back('{"rnd_rdn",    32'h3F800001, 32'h3F800001, 2'b10, 32'h3F800002});
    vecs.push_back('{"rnd_rup",    32'h3F800001, 32'h3F800001, 2'b11, 32'h3F800003});
    vecs.push_back('{"inf_x0",     32'h7F800000, 32'h00000000, 2'b00, 32'h7FC00000});
    vecs.push_back('{"ninf_x2",    32'hFF800000, 32'h40000000, 2'b00, 32'hFF800000});
    vecs.push_back('{"nan_in",     32'h7FC00001, 32'h3F800000, 2'b00, 32'h7FC00000});
    vecs.push_back('{"ovf_rne",    32'h7F7FFFFF, 32'h40000000, 2'b00, 32'h7F800000});
    vecs.push_back('{"ovf_rtz",    32'h7F7FFFFF, 32'h40000000, 2'b01, 32'h7F7FFFFF});
    vecs.push_back('{"ovf_neg_up", 32'hFF7FFFFF, 32'h40000000, 2'b11, 32'hFF7FFFFF});
    vecs.push_back('{"ovf_neg_dn", 32'hFF7FFFFF, 32'h40000000, 2'b10, 32'hFF800000});
    vecs.push_back('{"ovf_pos_up", 32'h7F7FFFFF, 32'h40000000, 2'b11, 32'h7F800000});
    vecs.push_back('{"sub_half",   32'h00800000, 32'h3F000000, 2'b00, 32'h00400000});
    vecs.push_back('{"sub_rne",    32'h00000001, 32'h3F000000, 2'b00, 32'h00000000});
    vecs.push_back('{"sub_rup",    32'h00000001, 32'h3F000000, 2'b11, 32'h00000001});
    vecs.push_back('{"sub_to_min", 32'h00FFFFFF, 32'h3F000000, 2'b11, 32'h00800000});
    vecs.push_back('{"zero_xinf",  32'h80000000, 32'h7F800000, 2'b00, 32'h7FC00000});

    $display("[TB] reset phase");
    applyStimulus("reset0", 1'b0, 'x, 'x, 'x, 32'h00000000);
    applyStimulus("reset1", 1'b0, 32'hFF7FFFFF, 32'h40000000, 2'b11, 32'h00000000);

    $display("[TB] directed vectors");
    foreach (vecs[i])
      applyStimulus(vecs[i].name, 1'b1, vecs[i].a, vecs[i].b, vecs[i].rnd, vecs[i].expv);

    $display("[TB] mid-stream reset");
    applyStimulus("pre_rst",  1'b1, 32'h3F800000, 32'h3F800000, 2'b00, 32'h3F800000);
    applyStimulus("rst_mid",  1'b0, 32'h40000000, 32'h40400000, 2'b00, 32'h00000000);
    applyStimulus("post_rst", 1'b1, 32'h40000000, 32'h40400000, 2'b00, 32'h40C00000);

    $display("[TB] random back-to-back");
    for (int i = 0; i < 250; i++) begin
      ra = randOp();
      rb = randOp();
      for (int md = 0; md < 4; md++)
        applyStimulus($sformatf("rand%0d_m%0d", i, md), 1'b1, ra, rb, 2'(md),
                      fpModel(ra, rb, 2'(md)));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: pending=%0d required=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
